// File: rtl/lcd_pkg.sv
// lcd_pkg: FSM state types, HD44780 command bytes, shared character codes
// and small helpers for the LCD write controller.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWR_WAIT,
      ST_INIT,
      ST_IDLE,
      ST_ADDR,
      ST_DATA
   } lcd_state_e;

   typedef enum logic [1:0] {
      BW_IDLE,
      BW_SETUP,
      BW_EN,
      BW_WAIT
   } bw_phase_e;

   localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
   localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
   localparam logic [7:0] LCD_CMD_DDRAM0   = 8'h80;

   // index of the last entry of the power-on command list
   localparam logic [2:0] INIT_LAST = 3'd5;

   // character codes shared with the display formatter
   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_MINUS = 8'h2D;
   localparam logic [7:0] CHAR_DOT   = 8'h2E;
   localparam logic [7:0] CHAR_ZERO  = 8'h30;

   // power-on command ROM
   function automatic logic [7:0] init_cmd(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd2: init_cmd = LCD_CMD_FUNC_SET;
         3'd3:             init_cmd = LCD_CMD_DISP_ON;
         3'd4:             init_cmd = LCD_CMD_CLEAR;
         default:          init_cmd = LCD_CMD_ENTRY;
      endcase
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      max3 = (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: one bus transfer to the LCD. Latches rs/data on start,
// holds them SETUP_CYC cycles, raises E for EN_CYC cycles, then keeps the
// bus stable through the post-E wait (CMD_CYC, or CLR_CYC when long_wait_i).
// done_o is high in the final wait cycle so the next start can follow
// back-to-back without a gap cycle.
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC = 2,
   parameter int EN_CYC    = 12,
   parameter int CMD_CYC   = 2000,
   parameter int CLR_CYC   = 82000,
   parameter int CW        = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       rs_i,
   input  logic [7:0] data_i,
   input  logic       long_wait_i,
   output logic       done_o,
   output logic       lcd_rs_o,
   output logic       lcd_en_o,
   output logic [7:0] lcd_data_o
);

   localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] EN_LOAD    = CW'(EN_CYC - 1);
   localparam logic [CW-1:0] CMD_LOAD   = CW'(CMD_CYC - 1);
   localparam logic [CW-1:0] CLR_LOAD   = CW'(CLR_CYC - 1);

   bw_phase_e     phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rs_q, rs_d;
   logic [7:0]    data_q, data_d;
   logic          long_q, long_d;
   logic          last;

   assign last   = (cnt_q == '0);
   assign done_o = (phase_q == BW_WAIT) && last;

   // phase sequencing; counter only decrements when non-zero, so it never wraps
   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      rs_d    = rs_q;
      data_d  = data_q;
      long_d  = long_q;
      case (phase_q)
         BW_SETUP: begin
            if (last) begin
               phase_d = BW_EN;
               cnt_d   = EN_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         BW_EN: begin
            if (last) begin
               phase_d = BW_WAIT;
               cnt_d   = long_q ? CLR_LOAD : CMD_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         BW_WAIT: begin
            if (last) phase_d = BW_IDLE;
            else      cnt_d   = cnt_q - 1'b1;
         end
         default: ;
      endcase
      if (start_i && ((phase_q == BW_IDLE) || done_o)) begin
         phase_d = BW_SETUP;
         cnt_d   = SETUP_LOAD;
         rs_d    = rs_i;
         data_d  = data_i;
         long_d  = long_wait_i;
      end
   end

   // phase, counter and latched bus registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= BW_IDLE;
         cnt_q   <= '0;
         rs_q    <= 1'b0;
         data_q  <= '0;
         long_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         long_q  <= long_d;
      end
   end

   assign lcd_rs_o   = rs_q;
   assign lcd_data_o = data_q;
   assign lcd_en_o   = (phase_q == BW_EN);

endmodule

// File: rtl/lcd_write_ctrl.sv
// lcd_write_ctrl: HD44780 8-bit sequencer, line 1 only. Runs the power-on
// init, then on request snapshots disp_in and writes it to DDRAM address 0.
// Optional feature macro: LCD_AUTO_REFRESH_EN (periodic self-triggered write).
module lcd_write_ctrl
   import lcd_pkg::*;
#(
   parameter int CHARS       = 20,
   parameter int SETUP_CYC   = 2,
   parameter int EN_CYC      = 12,
   parameter int CMD_CYC     = 2000,
   parameter int CLR_CYC     = 82000,
   parameter int PWR_CYC     = 750000,
   parameter int REFRESH_CYC = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       update,
   input  logic [7:0] disp_in [CHARS-1:0],
   output logic       ready,
   output logic       init_done,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic [7:0] lcd_data
);

   localparam int CW = $clog2(max3(PWR_CYC, CLR_CYC, REFRESH_CYC) + 1);
   localparam int IW = (CHARS > 1) ? $clog2(CHARS) : 1;

   lcd_state_e    state_q, state_d;
   logic [CW-1:0] pwr_cnt_q;
   logic [2:0]    init_idx_q;
   logic [IW-1:0] chr_idx_q;
   logic [7:0]    snap_q [CHARS-1:0];
   logic          init_done_q;
   logic          pwr_done, accept, refresh_req;
   logic          wr_start, wr_rs, wr_long, wr_done;
   logic [7:0]    wr_data;

   assign pwr_done = (pwr_cnt_q == CW'(PWR_CYC - 1));
   assign accept   = (state_q == ST_IDLE) && (update || refresh_req);

`ifdef LCD_AUTO_REFRESH_EN
   logic [CW-1:0] ref_cnt_q;
   logic          pend_q;
   logic          ref_exp;

   assign ref_exp     = init_done_q && (ref_cnt_q == CW'(REFRESH_CYC - 1));
   assign refresh_req = pend_q || ref_exp;

   // refresh timer runs from init_done and restarts on every accepted write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt_q <= '0;
         pend_q    <= 1'b0;
      end else begin
         if (!init_done_q || accept || ref_exp) ref_cnt_q <= '0;
         else                                   ref_cnt_q <= ref_cnt_q + 1'b1;
         if (accept)       pend_q <= 1'b0;
         else if (ref_exp) pend_q <= 1'b1;
      end
   end
`else
   assign refresh_req = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_PWR_WAIT;
      else        state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_PWR_WAIT: if (pwr_done) state_d = ST_INIT;
         ST_INIT:     if (wr_done && init_idx_q == INIT_LAST) state_d = ST_IDLE;
         ST_IDLE:     if (accept) state_d = ST_ADDR;
         ST_ADDR:     if (wr_done) state_d = ST_DATA;
         ST_DATA:     if (wr_done && chr_idx_q == '0) state_d = ST_IDLE;
         default:     state_d = ST_PWR_WAIT;
      endcase
   end

   // FSM outputs: each start is issued in the cycle the previous byte finishes
   always_comb begin
      wr_start = 1'b0;
      wr_rs    = 1'b0;
      wr_data  = '0;
      wr_long  = 1'b0;
      case (state_q)
         ST_PWR_WAIT: begin
            if (pwr_done) begin
               wr_start = 1'b1;
               wr_data  = init_cmd(3'd0);
            end
         end
         ST_INIT: begin
            if (wr_done && init_idx_q != INIT_LAST) begin
               wr_start = 1'b1;
               wr_data  = init_cmd(init_idx_q + 3'd1);
               wr_long  = (wr_data == LCD_CMD_CLEAR);
            end
         end
         ST_IDLE: begin
            if (accept) begin
               wr_start = 1'b1;
               wr_data  = LCD_CMD_DDRAM0;
            end
         end
         ST_ADDR: begin
            if (wr_done) begin
               wr_start = 1'b1;
               wr_rs    = 1'b1;
               wr_data  = snap_q[CHARS-1];
            end
         end
         ST_DATA: begin
            if (wr_done && chr_idx_q != '0) begin
               wr_start = 1'b1;
               wr_rs    = 1'b1;
               wr_data  = snap_q[chr_idx_q - 1'b1];
            end
         end
         default: ;
      endcase
   end

   // power-on timer, init ROM index, char index and snapshot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwr_cnt_q   <= '0;
         init_idx_q  <= '0;
         chr_idx_q   <= '0;
         init_done_q <= 1'b0;
         for (int i = 0; i < CHARS; i++) snap_q[i] <= '0;
      end else begin
         if (state_q == ST_PWR_WAIT && !pwr_done) pwr_cnt_q <= pwr_cnt_q + 1'b1;
         if (state_q == ST_INIT && wr_done) begin
            if (init_idx_q == INIT_LAST) init_done_q <= 1'b1;
            else                         init_idx_q  <= init_idx_q + 3'd1;
         end
         if (accept) snap_q <= disp_in;
         if (state_q == ST_ADDR && wr_done)
            chr_idx_q <= IW'(CHARS - 1);
         else if (state_q == ST_DATA && wr_done && chr_idx_q != '0)
            chr_idx_q <= chr_idx_q - 1'b1;
      end
   end

   lcd_byte_writer #(
      .SETUP_CYC (SETUP_CYC),
      .EN_CYC    (EN_CYC),
      .CMD_CYC   (CMD_CYC),
      .CLR_CYC   (CLR_CYC),
      .CW        (CW)
   ) u_writer (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (wr_start),
      .rs_i        (wr_rs),
      .data_i      (wr_data),
      .long_wait_i (wr_long),
      .done_o      (wr_done),
      .lcd_rs_o    (lcd_rs),
      .lcd_en_o    (lcd_en),
      .lcd_data_o  (lcd_data)
   );

   assign lcd_rw    = 1'b0;
   assign ready     = (state_q == ST_IDLE);
   assign init_done = init_done_q;

endmodule
